// File: rtl/uart_tx_drain.sv
// ============================================================================
// uart_tx_drain : pops bytes from a FWFT FIFO and sends 8N1 frames, LSB first,
//                 gated by a synchronised active-low CTS input.
// Optional macro: UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_drain #(
  parameter int BAUD_W = 24
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [BAUD_W-1:0] i_baud_div,
  input  logic              i_empty_n,
  input  logic [7:0]        i_data,
  output logic              o_rd,
  input  logic              i_cts_n,
  output logic              o_uart_tx,
  output logic              o_busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [BAUD_W-1:0] MIN_DIV = BAUD_W'(2);

  logic [2:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] div_lat;
  logic [BAUD_W-1:0] div_clamped;
  logic [7:0]        shift;
  logic [2:0]        bit_idx;
  logic              tx;
  logic              cts_meta;
  logic              cts_s;
  logic              last_cycle;
  logic              pop;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  // Both synchroniser stages come out of reset as "not clear".
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
    end else begin
      cts_meta <= i_cts_n;
      cts_s    <= cts_meta;
    end
  end

  assign div_clamped = (i_baud_div < MIN_DIV) ? MIN_DIV : i_baud_div;
  assign last_cycle  = (baud_cnt == '0);

  // A pop on the final stop cycle chains the next start bit with no idle gap.
  assign pop = !i_reset && i_empty_n && !cts_s &&
               ((state == IDLE) || ((state == STOP) && last_cycle));

  assign o_rd      = pop;
  assign o_uart_tx = tx;
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_lat  <= MIN_DIV;
      shift    <= 8'h00;
      bit_idx  <= 3'd0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (pop) begin
      state    <= START;
      shift    <= i_data;
      div_lat  <= div_clamped;
      baud_cnt <= div_clamped - BAUD_W'(1);
      bit_idx  <= 3'd0;
      tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^i_data;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
        end

        START: begin
          if (last_cycle) begin
            state    <= DATA;
            baud_cnt <= div_lat - BAUD_W'(1);
            bit_idx  <= 3'd0;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        DATA: begin
          if (last_cycle) begin
            baud_cnt <= div_lat - BAUD_W'(1);
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (last_cycle) begin
            state    <= STOP;
            baud_cnt <= div_lat - BAUD_W'(1);
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end
`endif

        STOP: begin
          // Reaching here on the last cycle means no pop was possible.
          if (last_cycle) begin
            state <= IDLE;
            tx    <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
// Testbench for uart_tx_drain: a cycle-level line-waveform model plus a FIFO model.
`default_nettype none

module tb_uart_tx_drain;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0;
  logic        i_reset;
  logic [23:0] i_baud_div;
  logic        i_empty_n;
  logic [7:0]  i_data;
  logic        o_rd;
  logic        i_cts_n;
  logic        o_uart_tx;
  logic        o_busy;

  uart_tx_drain #(.BAUD_W(24)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_baud_div(i_baud_div),
    .i_empty_n(i_empty_n), .i_data(i_data), .o_rd(o_rd),
    .i_cts_n(i_cts_n), .o_uart_tx(o_uart_tx), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] fifo[$];
  logic       line_q[$];
  int         edges = 0;
  logic       h0 = 1'b1, h1 = 1'b1;

  logic tx_s, busy_s, rd_s;
  logic exp_tx, exp_busy, exp_rd;

  task automatic add_frame(input logic [7:0] b, input int d);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]  = ^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
    f[10] = 1'b1;
`endif
    for (int i = 0; i < FB; i++)
      for (int j = 0; j < d; j++)
        line_q.push_back(f[i]);
  endtask

  // One clock: sample at negedge, predict, then advance FIFO and CTS history.
  task automatic step();
    int d;
    logic clear;
    @(negedge clk);
    tx_s = o_uart_tx; busy_s = o_busy; rd_s = o_rd;
    if (line_q.size() > 0) begin
      exp_tx = line_q.pop_front(); exp_busy = 1'b1;
    end else begin
      exp_tx = 1'b1; exp_busy = 1'b0;
    end
    clear  = (edges >= 2) ? !h1 : 1'b0;
    exp_rd = !i_reset && (fifo.size() > 0) && clear && (line_q.size() == 0);
    if (exp_rd) begin
      d = (i_baud_div < 2) ? 2 : int'(i_baud_div);
      add_frame(fifo[0], d);
    end
    @(posedge clk);
    if (i_reset) begin
      line_q.delete(); edges = 0; h0 = 1'b1; h1 = 1'b1;
    end else begin
      h1 = h0; h0 = i_cts_n; edges++;
    end
    if (rd_s && fifo.size() > 0) void'(fifo.pop_front());
    #1;
    i_empty_n = (fifo.size() > 0);
    i_data    = (fifo.size() > 0) ? fifo[0] : 8'h00;
    cyc++;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    i_empty_n = 1'b1;
    i_data    = fifo[0];
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({tx_s, busy_s, rd_s} !== 3'b100) begin
        failures++;
        $display("FAIL reset_state cyc=%0d tx/busy/rd got=%b%b%b exp=100", cyc, tx_s, busy_s, rd_s);
      end
    end
    i_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
      end
    end
  endtask

  task automatic test_single();
    int rd_cnt = 0, busy_cnt = 0;
    i_baud_div = 24'd4;
    push(8'hA5);
    for (int k = 0; k < FB*4 + 6; k++) begin
      step();
      rd_cnt += rd_s; busy_cnt += busy_s;
      checks++;
      if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
        failures++;
        $display("FAIL single_wave cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
      end
    end
    checks++;
    if (rd_cnt != 1) begin failures++; $display("FAIL single_rd_count got=%0d exp=1", rd_cnt); end
    checks++;
    if (busy_cnt != FB*4) begin failures++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, FB*4); end
  endtask

  task automatic test_back_to_back();
    int busy_cnt = 0, run = 0, max_run = 0, r0 = -1, r1 = -1;
    i_baud_div = 24'd4;
    push(8'h00); push(8'hFF);
    for (int k = 0; k < 2*FB*4 + 6; k++) begin
      step();
      if (rd_s && r0 < 0) r0 = k; else if (rd_s && r1 < 0) r1 = k;
      busy_cnt += busy_s;
      run = busy_s ? run + 1 : 0;
      if (run > max_run) max_run = run;
      checks++;
      if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
        failures++;
        $display("FAIL b2b_wave cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
      end
    end
    checks++;
    if (r1 - r0 != FB*4 || r0 < 0) begin failures++; $display("FAIL b2b_rd_spacing got=%0d exp=%0d", r1 - r0, FB*4); end
    checks++;
    if (max_run != 2*FB*4 || busy_cnt != 2*FB*4) begin
      failures++; $display("FAIL b2b_contiguous got run=%0d total=%0d exp=%0d", max_run, busy_cnt, 2*FB*4);
    end
  endtask

  task automatic test_flow_control();
    int rd_cnt = 0, first = -1;
    logic [7:0] b;
    i_cts_n = 1'b1;
    i_baud_div = 24'd3;
    for (int k = 0; k < 3; k++) step();
    b = 8'($urandom);
    push(b);
    for (int k = 0; k < 6; k++) begin
      step();
      rd_cnt += rd_s;
      checks++;
      if ({tx_s, busy_s, rd_s} !== 3'b100 || {exp_tx, exp_busy, exp_rd} !== 3'b100) begin
        failures++;
        $display("FAIL cts_block cyc=%0d got=%b%b%b exp=100", cyc, tx_s, busy_s, rd_s);
      end
    end
    i_cts_n = 1'b0;
    for (int k = 1; k <= FB*3 + 8; k++) begin
      step();
      if (rd_s && first < 0) first = k;
      checks++;
      if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
        failures++;
        $display("FAIL cts_wave cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
      end
    end
    checks++;
    if (first != 3) begin failures++; $display("FAIL cts_latency got=%0d exp=3", first); end
  endtask

  task automatic test_reset_mid();
    int wait_n = 0;
    logic seen = 1'b0;
    i_baud_div = 24'd4;
    push(8'($urandom)); push(8'($urandom));
    for (int k = 0; k < 19; k++) begin
      step();
      checks++;
      if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
        failures++;
        $display("FAIL rstmid_pre cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
      end
    end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    for (int k = 0; k < FB*4 + 8; k++) begin
      step();
      if (k == 0) begin
        checks++;
        if ({tx_s, busy_s} !== 2'b10) begin
          failures++; $display("FAIL rstmid_abort got tx/busy=%b%b exp=10", tx_s, busy_s);
        end
      end
      if (rd_s) seen = 1'b1;
      if (!seen) wait_n++;
      checks++;
      if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
        failures++;
        $display("FAIL rstmid_wave cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
      end
    end
    checks++;
    if (wait_n < 2 || !seen) begin failures++; $display("FAIL rstmid_rd_wait got=%0d exp>=2", wait_n); end
  endtask

  task automatic test_clamp_div();
    int busy_cnt, r0, r1;
    for (int dv = 0; dv < 2; dv++) begin
      busy_cnt = 0;
      i_baud_div = 24'(dv);
      push(8'($urandom));
      for (int k = 0; k < FB*2 + 5; k++) begin
        step();
        busy_cnt += busy_s;
        checks++;
        if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
          failures++;
          $display("FAIL clamp_wave cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
        end
      end
      checks++;
      if (busy_cnt != FB*2) begin failures++; $display("FAIL clamp_len div=%0d got=%0d exp=%0d", dv, busy_cnt, FB*2); end
    end
    busy_cnt = 0; r0 = -1; r1 = -1;
    i_baud_div = 24'd4;
    push(8'h3C); push(8'hC3);
    for (int k = 0; k < FB*12 + 6; k++) begin
      step();
      if (k == 10) i_baud_div = 24'd8;
      if (rd_s && r0 < 0) r0 = k; else if (rd_s && r1 < 0) r1 = k;
      busy_cnt += busy_s;
      checks++;
      if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
        failures++;
        $display("FAIL divchg_wave cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
      end
    end
    checks++;
    if (r1 - r0 != FB*4 || r0 < 0) begin failures++; $display("FAIL divchg_first_len got=%0d exp=%0d", r1 - r0, FB*4); end
    checks++;
    if (busy_cnt != FB*12) begin failures++; $display("FAIL divchg_total got=%0d exp=%0d", busy_cnt, FB*12); end
  endtask

  task automatic test_random();
    int n, d;
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(0, 5);
      n = $urandom_range(1, 3);
      i_baud_div = 24'(d);
      i_cts_n = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) push(8'($urandom));
      for (int k = 0; k < n*FB*6 + 12; k++) begin
        if (k == 4) i_cts_n = 1'b0;
        step();
        checks++;
        if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
          failures++;
          $display("FAIL random_wave cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
        end
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int busy_cnt = 0, p = -1;
    logic par_seen = 1'b0, stop_seen = 1'b0;
    i_baud_div = 24'd2;
    push(8'h07);
    for (int k = 0; k < 28; k++) begin
      step();
      if (rd_s && p < 0) p = k;
      if (p >= 0 && k == p + 19) par_seen = tx_s;
      if (p >= 0 && k == p + 21) stop_seen = tx_s;
      busy_cnt += busy_s;
      checks++;
      if ({tx_s, busy_s, rd_s} !== {exp_tx, exp_busy, exp_rd}) begin
        failures++;
        $display("FAIL parity_wave cyc=%0d got=%b%b%b exp=%b%b%b", cyc, tx_s, busy_s, rd_s, exp_tx, exp_busy, exp_rd);
      end
    end
    checks++;
    if (par_seen !== 1'b1 || stop_seen !== 1'b1 || busy_cnt != 22) begin
      failures++; $display("FAIL parity_frame got par=%b stop=%b len=%0d exp par=1 stop=1 len=22", par_seen, stop_seen, busy_cnt);
    end
  endtask
`endif

  initial begin
    i_reset = 1'b1; i_baud_div = 24'd4; i_empty_n = 1'b0; i_data = 8'h00; i_cts_n = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_flow_control();
    test_reset_mid();
    test_clamp_div();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
